// File: rtl/lampFPU_pkg.sv
// Shared lampFPU definitions: float width, log-requester FSM states and the
// bfloat16 operand classifier.
package lampFPU_pkg;

  localparam int LAMP_FLOAT_DW   = 16;
  localparam int LAMP_FLOAT_E_DW = 8;
  localparam int LAMP_FLOAT_F_DW = 7;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} lamp_log_req_state_t;

  // Returns {isZ, isInf, isSNAN, isQNAN}; subnormals fold into isZ.
  function automatic logic [3:0] lampFPU_classify(
    input logic [LAMP_FLOAT_E_DW-1:0] e,
    input logic [LAMP_FLOAT_F_DW-1:0] f
  );
    logic eMax;
    eMax = &e;
    return {e == '0, eMax && (f == '0), eMax && (f != '0) && !f[6], eMax && f[6]};
  endfunction

endpackage

// File: rtl/lamp_fpu_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after ptr, wrapping,
// and returns the pointer to use after that grant. Purely combinational.
module lamp_fpu_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int TAG_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [TAG_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [TAG_W-1:0] grantIdx,
  output logic             grantValid,
  output logic [TAG_W-1:0] nextPtr
);

  always_comb begin
    int idx;
    logic [TAG_W-1:0] idxT;
    grant      = '0;
    grantIdx   = '0;
    grantValid = 1'b0;
    nextPtr    = ptr;
    idx        = 0;
    idxT       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idxT = TAG_W'(idx);
      if (!grantValid && req[idxT]) begin
        grantValid  = 1'b1;
        grant[idxT] = 1'b1;
        grantIdx    = idxT;
        nextPtr     = (idx == N_REQ - 1) ? '0 : TAG_W'(idx + 1);
      end
    end
  end

endmodule

// File: rtl/lamp_fpu_log_arbiter.sv
// Shares one registered-latency lampFPU log unit among N_REQ requesters:
// classifies and issues operands round-robin, then routes tagged results back.
//
// state | meaning
// IDLE  | nothing owned; eligible for a grant while req_valid_i is high
// BUSY  | operand issued, waiting for its tagged result
// DONE  | result held in the response slot until rsp_ready_i
module lamp_fpu_log_arbiter
  import lampFPU_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int LOG_LAT = 1,
  parameter int TAG_W   = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid_i,
  output logic [N_REQ-1:0]           req_ready_o,
  input  logic [N_REQ*16-1:0]        req_op_i,
  output logic                       log_do_o,
  output logic                       log_s_o,
  output logic [7:0]                 log_e_o,
  output logic [6:0]                 log_f_o,
  output logic                       log_isZ_o,
  output logic                       log_isInf_o,
  output logic                       log_isSNAN_o,
  output logic                       log_isQNAN_o,
  input  logic                       log_valid_i,
  input  logic                       log_s_i,
  input  logic [7:0]                 log_e_i,
  input  logic [6:0]                 log_f_i,
  input  logic                       log_ovf_i,
  input  logic                       log_unf_i,
  input  logic                       log_rnd_i,
  output logic [N_REQ-1:0]           rsp_valid_o,
  input  logic [N_REQ-1:0]           rsp_ready_i,
  output logic [N_REQ*16-1:0]        rsp_res_o,
  output logic [N_REQ*3-1:0]         rsp_flags_o,
  output logic                       err_o
);

  localparam int BLANK_W = $clog2(LOG_LAT + 1);

  lamp_log_req_state_t state     [N_REQ];
  lamp_log_req_state_t stateNext [N_REQ];

  logic [N_REQ-1:0]                    eligible, grant, resHit;
  logic [TAG_W-1:0]                    rrPtr, rrPtrNext, grantIdx, issueTag;
  logic                                grantValid;
  logic [LAMP_FLOAT_DW-1:0]            grantOp;
  logic [3:0]                          grantCls;
  logic [LOG_LAT-1:0]                  pipeValid;
  logic [LOG_LAT-1:0][TAG_W-1:0]       pipeTag;
  logic                                headValid;
  logic [TAG_W-1:0]                    headTag;
  logic [BLANK_W-1:0]                  blankCnt;
  logic [N_REQ-1:0][LAMP_FLOAT_DW-1:0] resBuf;
  logic [N_REQ-1:0][2:0]               flagBuf;

  always_comb begin
    eligible = '0;
    for (int k = 0; k < N_REQ; k++) eligible[k] = req_valid_i[k] && (state[k] == IDLE);
  end

  lamp_fpu_rr_arbiter #(.N_REQ(N_REQ), .TAG_W(TAG_W)) uArb (
    .req        (eligible),
    .ptr        (rrPtr),
    .grant      (grant),
    .grantIdx   (grantIdx),
    .grantValid (grantValid),
    .nextPtr    (rrPtrNext)
  );

  assign req_ready_o = grant;
  assign grantOp     = req_op_i[int'(grantIdx)*LAMP_FLOAT_DW +: LAMP_FLOAT_DW];
  assign grantCls    = lampFPU_classify(grantOp[14:7], grantOp[6:0]);

  // Operand outputs hold their last value between issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      log_do_o     <= 1'b0;
      log_s_o      <= 1'b0;
      log_e_o      <= '0;
      log_f_o      <= '0;
      log_isZ_o    <= 1'b0;
      log_isInf_o  <= 1'b0;
      log_isSNAN_o <= 1'b0;
      log_isQNAN_o <= 1'b0;
      issueTag     <= '0;
    end else begin
      log_do_o <= grantValid;
      if (grantValid) begin
        {log_s_o, log_e_o, log_f_o} <= grantOp;
        {log_isZ_o, log_isInf_o, log_isSNAN_o, log_isQNAN_o} <= grantCls;
        issueTag <= grantIdx;
      end
    end
  end

  // Entry 0 is loaded as the log unit samples doLog; the head meets log_valid_i.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipeValid <= '0;
      pipeTag   <= '0;
    end else begin
      pipeValid[0] <= log_do_o;
      pipeTag[0]   <= issueTag;
      for (int i = 1; i < LOG_LAT; i++) begin
        pipeValid[i] <= pipeValid[i-1];
        pipeTag[i]   <= pipeTag[i-1];
      end
    end
  end

  assign headValid = pipeValid[LOG_LAT-1];
  assign headTag   = pipeTag[LOG_LAT-1];

  always_comb begin
    resHit = '0;
    for (int k = 0; k < N_REQ; k++) resHit[k] = log_valid_i && headValid && (headTag == TAG_W'(k));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_REQ; k++) state[k] <= IDLE;
    end else begin
      for (int k = 0; k < N_REQ; k++) state[k] <= stateNext[k];
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      stateNext[k] = state[k];
      unique case (state[k])
        IDLE:    if (grant[k])       stateNext[k] = BUSY;
        BUSY:    if (resHit[k])      stateNext[k] = DONE;
        DONE:    if (rsp_ready_i[k]) stateNext[k] = IDLE;
        default:                     stateNext[k] = IDLE;
      endcase
      rsp_valid_o[k] = (state[k] == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resBuf  <= '0;
      flagBuf <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (resHit[k]) begin
          resBuf[k]  <= {log_s_i, log_e_i, log_f_i};
          flagBuf[k] <= {log_ovf_i, log_unf_i, log_rnd_i};
        end
      end
    end
  end

  assign rsp_res_o   = resBuf;
  assign rsp_flags_o = flagBuf;

  // blankCnt masks results that were in flight when reset hit the log unit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrPtr    <= '0;
      blankCnt <= BLANK_W'(LOG_LAT);
      err_o    <= 1'b0;
    end else begin
      if (grantValid) rrPtr <= rrPtrNext;
      if (blankCnt != '0) blankCnt <= blankCnt - BLANK_W'(1);
      if ((blankCnt == '0) && (log_valid_i != headValid)) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lamp_fpu_log_arbiter.sv
// Randomized bench for lamp_fpu_log_arbiter: a behavioural log unit partner
// plus a requester/ownership model built from grant order and fixed latency.
module tb_lamp_fpu_log_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0]    req_valid_i = '0, req_ready_o, rsp_valid_o, rsp_ready_i = '0;
  logic [N*16-1:0] req_op_i = '0, rsp_res_o;
  logic [N*3-1:0]  rsp_flags_o;
  logic log_do_o, log_s_o, log_isZ_o, log_isInf_o, log_isSNAN_o, log_isQNAN_o, err_o;
  logic [7:0] log_e_o;
  logic [6:0] log_f_o;
  logic log_valid_i = 1'b0, log_s_i = 1'b0, log_ovf_i = 1'b0, log_unf_i = 1'b0, log_rnd_i = 1'b0;
  logic [7:0] log_e_i = '0;
  logic [6:0] log_f_i = '0;

  lamp_fpu_log_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .log_do_o(log_do_o), .log_s_o(log_s_o), .log_e_o(log_e_o), .log_f_o(log_f_o),
    .log_isZ_o(log_isZ_o), .log_isInf_o(log_isInf_o),
    .log_isSNAN_o(log_isSNAN_o), .log_isQNAN_o(log_isQNAN_o),
    .log_valid_i(log_valid_i), .log_s_i(log_s_i), .log_e_i(log_e_i), .log_f_i(log_f_i),
    .log_ovf_i(log_ovf_i), .log_unf_i(log_unf_i), .log_rnd_i(log_rnd_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_res_o(rsp_res_o), .rsp_flags_o(rsp_flags_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int vectors = 0, errors = 0;

  // Reference model: 0 = free, 1 = waiting on result, 2 = holding response.
  int          mState [N];
  logic [15:0] mRes [N];
  logic [2:0]  mFlg [N];
  int          mPtr = 0, cyc = 0;
  bit          mErr = 0, expDo = 0, logPend = 0, injectValid = 0;
  logic [15:0] expOp = '0;
  int          qOwner[$], qArrive[$];
  logic [N-1:0]    nValid = '0, nReady = '0;
  logic [N*16-1:0] nOp = '0;

  function automatic logic [3:0] clsOf(input logic [15:0] op);
    logic [7:0] e;
    logic [6:0] f;
    e = op[14:7];
    f = op[6:0];
    if (e == 8'h00) return 4'b1000;
    if (e != 8'hFF) return 4'b0000;
    if (f == 7'h00) return 4'b0100;
    return f[6] ? 4'b0001 : 4'b0010;
  endfunction

  task automatic apply_reset(input bit lateValid);
    rst = 1'b1;
    req_valid_i = '0; rsp_ready_i = '0; log_valid_i = lateValid;
    nValid = '0; nReady = '0; injectValid = 0;
    for (int k = 0; k < N; k++) mState[k] = 0;
    qOwner.delete(); qArrive.delete();
    mPtr = 0; mErr = 0; expDo = 0; logPend = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One clock: apply staged inputs, answer doLog, check at negedge, advance model.
  task automatic cycle();
    int g;
    bit owed;
    logic [N-1:0] expReady;
    @(posedge clk); #1;
    req_valid_i = nValid; rsp_ready_i = nReady; req_op_i = nOp;
    log_valid_i = logPend | injectValid;
    {log_s_i, log_e_i, log_f_i} = 16'($urandom);
    {log_ovf_i, log_unf_i, log_rnd_i} = 3'($urandom);
    @(negedge clk);
    g = -1;
    for (int i = 0; i < N; i++) begin
      int k = (mPtr + i) % N;
      if (g < 0 && req_valid_i[k] && mState[k] == 0) g = k;
    end
    expReady = '0;
    if (g >= 0) expReady[g] = 1'b1;
    vectors++;
    if (req_ready_o !== expReady) begin
      errors++; $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, req_ready_o, expReady);
    end
    vectors++;
    if (log_do_o !== expDo) begin
      errors++; $display("FAIL log_do cyc=%0d got=%b exp=%b", cyc, log_do_o, expDo);
    end
    if (expDo) begin
      vectors++;
      if ({log_s_o, log_e_o, log_f_o} !== expOp ||
          {log_isZ_o, log_isInf_o, log_isSNAN_o, log_isQNAN_o} !== clsOf(expOp)) begin
        errors++;
        $display("FAIL issue cyc=%0d got=%h/%b exp=%h/%b", cyc, {log_s_o, log_e_o, log_f_o},
                 {log_isZ_o, log_isInf_o, log_isSNAN_o, log_isQNAN_o}, expOp, clsOf(expOp));
      end
    end
    for (int k = 0; k < N; k++) begin
      vectors++;
      if (rsp_valid_o[k] !== (mState[k] == 2)) begin
        errors++; $display("FAIL rsp_valid[%0d] cyc=%0d got=%b exp=%b", k, cyc, rsp_valid_o[k], mState[k] == 2);
      end else if (mState[k] == 2 && (rsp_res_o[k*16 +: 16] !== mRes[k] || rsp_flags_o[k*3 +: 3] !== mFlg[k])) begin
        errors++;
        $display("FAIL rsp_data[%0d] cyc=%0d got=%h/%b exp=%h/%b", k, cyc,
                 rsp_res_o[k*16 +: 16], rsp_flags_o[k*3 +: 3], mRes[k], mFlg[k]);
      end
    end
    vectors++;
    if (err_o !== mErr) begin
      errors++; $display("FAIL err cyc=%0d got=%b exp=%b", cyc, err_o, mErr);
    end
    owed = (qOwner.size() > 0) && (qArrive[0] == cyc);
    if (log_valid_i != owed) mErr = 1;
    for (int k = 0; k < N; k++) if (mState[k] == 2 && rsp_ready_i[k]) mState[k] = 0;
    if (owed) begin
      int o;
      o = qOwner.pop_front();
      void'(qArrive.pop_front());
      if (log_valid_i) begin
        mState[o] = 2;
        mRes[o] = {log_s_i, log_e_i, log_f_i};
        mFlg[o] = {log_ovf_i, log_unf_i, log_rnd_i};
      end
    end
    expDo = (g >= 0);
    if (g >= 0) begin
      mState[g] = 1;
      qOwner.push_back(g);
      qArrive.push_back(cyc + 2);
      mPtr = (g + 1) % N;
      expOp = req_op_i[g*16 +: 16];
    end
    logPend = log_do_o;
    cyc++;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({req_ready_o, log_do_o, log_s_o, log_e_o, log_f_o, log_isZ_o, log_isInf_o, log_isSNAN_o,
         log_isQNAN_o, rsp_valid_o, rsp_res_o, rsp_flags_o, err_o} !== '0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", {log_do_o, rsp_valid_o, rsp_res_o, err_o});
    end
    apply_reset(0);
    nReady = '1;
    repeat (2) cycle();
  endtask

  task automatic test_single();
    logic [15:0] res;
    nValid = 4'b0001; nOp = '0; nOp[15:0] = 16'h3F80; nReady = '1;
    cycle();
    nValid = '0;
    vectors++;
    if (req_ready_o[0] !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", req_ready_o[0]); end
    cycle();
    vectors++;
    if (log_do_o !== 1'b1 || log_isZ_o !== 1'b0) begin
      errors++; $display("FAIL single_issue got do=%b z=%b exp do=1 z=0", log_do_o, log_isZ_o);
    end
    cycle();
    res = {log_s_i, log_e_i, log_f_i};
    cycle();
    vectors++;
    if (rsp_valid_o[0] !== 1'b1 || rsp_res_o[15:0] !== res) begin
      errors++; $display("FAIL single_rsp got v=%b res=%h exp v=1 res=%h", rsp_valid_o[0], rsp_res_o[15:0], res);
    end
    repeat (2) cycle();
  endtask

  task automatic test_classify();
    logic [15:0] ops [4] = '{16'h0000, 16'h7F80, 16'h7FC0, 16'h7F81};
    logic [3:0]  cls [4] = '{4'b1000, 4'b0100, 4'b0001, 4'b0010};
    for (int i = 0; i < 4; i++) begin
      nValid = 4'b0001; nOp[15:0] = ops[i]; nReady = '1;
      cycle();
      nValid = '0;
      cycle();
      vectors++;
      if ({log_isZ_o, log_isInf_o, log_isSNAN_o, log_isQNAN_o} !== cls[i]) begin
        errors++; $display("FAIL classify op=%h got=%b exp=%b", ops[i],
                           {log_isZ_o, log_isInf_o, log_isSNAN_o, log_isQNAN_o}, cls[i]);
      end
      repeat (2) cycle();
    end
  endtask

  task automatic test_round_robin();
    nValid = '1; nReady = '1;
    repeat (24) begin
      nOp = {$urandom, $urandom};
      cycle();
    end
    nValid = '0;
    repeat (4) cycle();
  endtask

  task automatic test_back_pressure();
    int grants = 0;
    nValid = 4'b0010; nReady = 4'b1101;
    repeat (10) begin
      nOp = {$urandom, $urandom};
      cycle();
      grants += int'(req_ready_o[1]);
    end
    vectors++;
    if (grants != 1) begin errors++; $display("FAIL bp_grants got=%0d exp=1", grants); end
    nReady = '1;
    cycle();
    vectors++;
    if (req_ready_o[1] !== 1'b0) begin errors++; $display("FAIL bp_same_cycle got=%b exp=0", req_ready_o[1]); end
    cycle();
    vectors++;
    if (req_ready_o[1] !== 1'b1) begin errors++; $display("FAIL bp_next_cycle got=%b exp=1", req_ready_o[1]); end
    nValid = '0;
    repeat (4) cycle();
  endtask

  task automatic test_random();
    repeat (300) begin
      nValid = 4'($urandom);
      nReady = 4'($urandom);
      for (int k = 0; k < N; k++) begin
        logic [15:0] op;
        op = 16'($urandom);
        case ($urandom_range(0, 3))
          0: op[14:7] = 8'h00;
          1: op[14:7] = 8'hFF;
          default: ;
        endcase
        nOp[k*16 +: 16] = op;
      end
      cycle();
    end
    nValid = '0; nReady = '1;
    repeat (5) cycle();
  endtask

  task automatic test_protocol_error();
    injectValid = 1;
    cycle();
    injectValid = 0;
    repeat (4) begin
      cycle();
      vectors++;
      if (err_o !== 1'b1 || rsp_valid_o !== '0) begin
        errors++; $display("FAIL proto_err got err=%b rsp=%b exp err=1 rsp=0", err_o, rsp_valid_o);
      end
    end
  endtask

  task automatic test_reset_midop();
    nValid = 4'b0011; nReady = '0; nOp = {$urandom, $urandom};
    cycle();
    cycle();
    nValid = '0;
    cycle();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({req_ready_o, log_do_o, log_s_o, log_e_o, log_f_o, log_isZ_o, log_isInf_o, log_isSNAN_o,
         log_isQNAN_o, rsp_valid_o, rsp_res_o, rsp_flags_o, err_o} !== '0) begin
      errors++; $display("FAIL midop_reset got=%h exp=0", {log_do_o, rsp_valid_o, rsp_res_o, err_o});
    end
    apply_reset(1);
    nReady = '1;
    repeat (5) cycle();
    nValid = '1;
    repeat (10) begin
      nOp = {$urandom, $urandom};
      cycle();
    end
    nValid = '0;
    repeat (5) cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_classify();
    test_round_robin();
    test_back_pressure();
    test_random();
    test_protocol_error();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
